// File: rtl/seg7_capture_decoder_if.sv
// Bus between a 7-segment display driver and the capture decoder that watches it.
// Latency: none, pure signal bundle.
// Backpressure: none, the segment bus is sampled every cycle and cannot stall.
interface seg7_capture_decoder_if #(
  parameter int COUNT_W = 8
);
  logic [6:0]         HEX_in;
  logic [3:0]         Value;
  logic               Valid;
  logic               Invalid;
  logic               Blank;
  logic               Update;
  logic [COUNT_W-1:0] ChangeCount;

  // Display side: drives segments, observes the decoded result.
  modport master (
    output HEX_in,
    input  Value, Valid, Invalid, Blank, Update, ChangeCount
  );

  // Decoder side.
  modport slave (
    input  HEX_in,
    output Value, Valid, Invalid, Blank, Update, ChangeCount
  );
endinterface

// File: rtl/seg7_capture_decoder.sv
// Samples an active-low HEX segment bus, debounces it and recovers the hex digit shown.
// Latency: a new pattern held from edge 1 commits and is visible after edge STABLE_CYCLES.
// Backpressure: none, every cycle is sampled; glitches shorter than STABLE_CYCLES are dropped.
module seg7_capture_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_W       = 8
) (
  input logic                   Clock,
  input logic                   Resetn,
  seg7_capture_decoder_if.slave bus
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);
  localparam logic [6:0] PAT_BLANK = 7'h7F;

  typedef enum logic {
    LOCKED = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [6:0]         r_samp;
  logic [6:0]         r_comm;
  logic [7:0]         r_cnt;
  logic [7:0]         w_cnt_nxt;
  logic               w_match;
  logic               w_commit;

  logic               w_is_digit;
  logic [3:0]         w_digit;
  logic               w_is_blank;

  logic [3:0]         r_value;
  logic               r_valid;
  logic               r_invalid;
  logic               r_blank;
  logic               r_update;
  logic [COUNT_W-1:0] r_count;

  // Pattern table: active-low segments g..a back to the digit they display.
  always_comb begin
    w_is_digit = 1'b1;
    w_digit    = 4'h0;
    w_is_blank = (bus.HEX_in == PAT_BLANK);
    case (bus.HEX_in)
      7'h40:   w_digit = 4'h0;
      7'h79:   w_digit = 4'h1;
      7'h24:   w_digit = 4'h2;
      7'h30:   w_digit = 4'h3;
      7'h19:   w_digit = 4'h4;
      7'h12:   w_digit = 4'h5;
      7'h02:   w_digit = 4'h6;
      7'h78:   w_digit = 4'h7;
      7'h00:   w_digit = 4'h8;
      7'h10:   w_digit = 4'h9;
      7'h08:   w_digit = 4'hA;
      7'h03:   w_digit = 4'hB;
      7'h46:   w_digit = 4'hC;
      7'h21:   w_digit = 4'hD;
      7'h06:   w_digit = 4'hE;
      7'h0E:   w_digit = 4'hF;
      default: w_is_digit = 1'b0;
    endcase
  end

  // Stability FSM next state: any change restarts the count, a full run of matches commits.
  always_comb begin
    w_match     = (bus.HEX_in == r_samp);
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    if (!w_match) begin
      w_cnt_nxt = 8'd1;
      if (STABLE_C == 8'd1) begin
        // A single sample is already stable enough: commit on the change itself.
        w_commit    = 1'b1;
        w_state_nxt = LOCKED;
      end else begin
        w_state_nxt = SETTLE;
      end
    end else if (r_state == SETTLE) begin
      // In SETTLE the count is always below STABLE_C, so this cannot overflow.
      w_cnt_nxt = r_cnt + 8'd1;
      if (w_cnt_nxt == STABLE_C) begin
        w_commit    = 1'b1;
        w_state_nxt = LOCKED;
      end
    end
  end

  // Stability FSM state, sample history and run counter.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= LOCKED;
      r_samp  <= PAT_BLANK;
      r_cnt   <= STABLE_C;
    end else begin
      r_state <= w_state_nxt;
      r_samp  <= bus.HEX_in;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Committed pattern and decoded status; Valid drops as soon as a change is pending.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_comm    <= PAT_BLANK;
      r_value   <= 4'h0;
      r_valid   <= 1'b0;
      r_invalid <= 1'b0;
      r_blank   <= 1'b1;
      r_update  <= 1'b0;
      r_count   <= '0;
    end else begin
      r_update <= w_commit;
      if (w_commit) begin
        r_comm <= bus.HEX_in;
        if (w_is_digit) begin
          r_value   <= w_digit;
          r_valid   <= 1'b1;
          r_invalid <= 1'b0;
          r_blank   <= 1'b0;
        end else if (w_is_blank) begin
          r_valid   <= 1'b0;
          r_invalid <= 1'b0;
          r_blank   <= 1'b1;
        end else begin
          r_valid   <= 1'b0;
          r_invalid <= 1'b1;
          r_blank   <= 1'b0;
        end
        // Re-committing the same pattern after a glitch is not a change.
        if (bus.HEX_in != r_comm) begin
          r_count <= r_count + COUNT_W'(1);
        end
      end else if (!w_match) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.Value       = r_value;
  assign bus.Valid       = r_valid;
  assign bus.Invalid     = r_invalid;
  assign bus.Blank       = r_blank;
  assign bus.Update      = r_update;
  assign bus.ChangeCount = r_count;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Bench for seg7_capture_decoder: two instances (8-bit and 2-bit change counters) share one
// segment stream; expected commits are queued when driven and popped on each Update pulse.
// Hand sequences cover reset, commit latency, glitch re-commit and reset during SETTLE.
module tb_seg7_capture_decoder;

  typedef struct {
    logic [3:0] val;
    bit         vld;
    bit         inv;
    bit         blk;
    logic [7:0] cc;
  } exp_t;

  typedef struct {
    logic [6:0] pat;
    int         hold;
    bit         commits;
    exp_t       e;
  } vec_t;

  logic Clock;
  logic Resetn;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t tbl[13];

  seg7_capture_decoder_if #(.COUNT_W(8)) bus_a ();
  seg7_capture_decoder_if #(.COUNT_W(2)) bus_b ();

  seg7_capture_decoder #(.STABLE_CYCLES(4), .COUNT_W(8)) dut_a (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus_a)
  );

  seg7_capture_decoder #(.STABLE_CYCLES(4), .COUNT_W(2)) dut_b (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [6:0] p);
    bus_a.HEX_in = p;
    bus_b.HEX_in = p;
  endtask

  task automatic push(input logic [3:0] v, input bit vl, input bit iv, input bit bk,
                      input logic [7:0] c);
    exp_t e;
    e.val = v; e.vld = vl; e.inv = iv; e.blk = bk; e.cc = c;
    sb.push_back(e);
  endtask

  // Scoreboard: every Update pulse must match the oldest queued commit.
  always @(negedge Clock) begin
    exp_t e;
    if (bus_a.Update === 1'b1 || bus_b.Update === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update: got update expected none at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("upd_a",   bus_a.Update,      1);
        chk("upd_b",   bus_b.Update,      1);
        chk("value",   bus_a.Value,       e.val);
        chk("valid",   bus_a.Valid,       e.vld);
        chk("invalid", bus_a.Invalid,     e.inv);
        chk("blank",   bus_a.Blank,       e.blk);
        chk("cc_a",    bus_a.ChangeCount, e.cc);
        chk("cc_b",    bus_b.ChangeCount, e.cc[1:0]);
        chk("value_b", bus_b.Value,       e.val);
      end
    end
  end

  initial begin
    // pattern, hold, commits, {value, valid, invalid, blank, change count}
    tbl[0]  = '{7'h7F, 6, 1'b1, '{4'h2, 1'b0, 1'b0, 1'b1, 8'd2}};
    tbl[1]  = '{7'h79, 6, 1'b1, '{4'h1, 1'b1, 1'b0, 1'b0, 8'd3}};
    tbl[2]  = '{7'h40, 6, 1'b1, '{4'h0, 1'b1, 1'b0, 1'b0, 8'd4}};
    tbl[3]  = '{7'h00, 6, 1'b1, '{4'h8, 1'b1, 1'b0, 1'b0, 8'd5}};
    tbl[4]  = '{7'h0E, 6, 1'b1, '{4'hF, 1'b1, 1'b0, 1'b0, 8'd6}};
    tbl[5]  = '{7'h00, 6, 1'b1, '{4'h8, 1'b1, 1'b0, 1'b0, 8'd7}};
    tbl[6]  = '{7'h55, 4, 1'b1, '{4'h8, 1'b0, 1'b1, 1'b0, 8'd8}};
    tbl[7]  = '{7'h40, 5, 1'b1, '{4'h0, 1'b1, 1'b0, 1'b0, 8'd9}};
    tbl[8]  = '{7'h79, 5, 1'b1, '{4'h1, 1'b1, 1'b0, 1'b0, 8'd10}};
    tbl[9]  = '{7'h40, 5, 1'b1, '{4'h0, 1'b1, 1'b0, 1'b0, 8'd11}};
    tbl[10] = '{7'h79, 5, 1'b1, '{4'h1, 1'b1, 1'b0, 1'b0, 8'd12}};
    tbl[11] = '{7'h12, 2, 1'b0, '{4'h0, 1'b0, 1'b0, 1'b0, 8'd0}};
    tbl[12] = '{7'h79, 6, 1'b1, '{4'h1, 1'b1, 1'b0, 1'b0, 8'd12}};

    // Reset state.
    Resetn = 1'b0;
    drive(7'h7F);
    repeat (2) @(negedge Clock);
    chk("rst_value",   bus_a.Value,       0);
    chk("rst_valid",   bus_a.Valid,       0);
    chk("rst_invalid", bus_a.Invalid,     0);
    chk("rst_blank",   bus_a.Blank,       1);
    chk("rst_update",  bus_a.Update,      0);
    chk("rst_cc",      bus_a.ChangeCount, 0);

    // Release with blank input: nothing must happen.
    Resetn = 1'b1;
    repeat (10) @(negedge Clock);
    chk("idle_blank", bus_a.Blank,       1);
    chk("idle_valid", bus_a.Valid,       0);
    chk("idle_cc",    bus_a.ChangeCount, 0);

    // Commit latency: Update only after the fourth edge.
    drive(7'h24);
    push(4'h2, 1'b1, 1'b0, 1'b0, 8'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clock);
      chk($sformatf("latency_upd_e%0d", k), bus_a.Update, (k == 4) ? 1 : 0);
    end
    repeat (2) @(negedge Clock);

    // Short glitch: Valid drops at once, Value holds, return re-commits without counting.
    drive(7'h30);
    @(negedge Clock);
    chk("glitch_valid", bus_a.Valid, 0);
    chk("glitch_value", bus_a.Value, 2);
    chk("glitch_blank", bus_a.Blank, 0);
    repeat (2) @(negedge Clock);
    drive(7'h24);
    push(4'h2, 1'b1, 1'b0, 1'b0, 8'd1);
    repeat (6) @(negedge Clock);

    // Table of patterns: digits, blank, invalid, counter wrap on the 2-bit instance.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].pat);
      if (tbl[i].commits) sb.push_back(tbl[i].e);
      repeat (tbl[i].hold) @(negedge Clock);
    end
    chk("tbl_cc_a", bus_a.ChangeCount, 12);
    chk("tbl_cc_b", bus_b.ChangeCount, 0);

    // Reset during SETTLE: outputs return immediately and the pending pattern is lost.
    drive(7'h21);
    repeat (2) @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    chk("mid_rst_value",   bus_a.Value,       0);
    chk("mid_rst_valid",   bus_a.Valid,       0);
    chk("mid_rst_invalid", bus_a.Invalid,     0);
    chk("mid_rst_blank",   bus_a.Blank,       1);
    chk("mid_rst_update",  bus_a.Update,      0);
    chk("mid_rst_cc_a",    bus_a.ChangeCount, 0);
    chk("mid_rst_cc_b",    bus_b.ChangeCount, 0);
    drive(7'h7F);
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (8) @(negedge Clock);
    chk("post_rst_blank", bus_a.Blank,       1);
    chk("post_rst_valid", bus_a.Valid,       0);
    chk("post_rst_cc",    bus_a.ChangeCount, 0);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_capture_decoder.md
Name: seg7_capture_decoder

Overview:
- Receiving end of the 7-segment display path: samples an active-low HEX segment bus and recovers the hex digit being shown.
- Same bit order and polarity as the board HEX outputs.
- A pattern is only accepted after it has been stable for STABLE_CYCLES clocks.
- Reports the value, validity, blank status and a count of committed digit changes, so display drivers can be self-checked in hardware.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples needed to commit a pattern; legal range 1..255.
COUNT_W, 8, width of ChangeCount.

Ports:
Clock  input  1  system clock, rising edge.
Resetn  input  1  asynchronous active-low reset.
HEX_in  input  7  observed segments, active-low: bit0=a, bit1=b, …, bit6=g.
Value  output  4  last committed valid digit 0x0..0xF.
Valid  output  1  committed pattern is a legal digit and no change is pending.
Invalid  output  1  committed pattern is neither a digit nor blank.
Blank  output  1  committed pattern is 7'h7F (all segments off).
Update  output  1  one-cycle pulse on every commit.
ChangeCount  output  COUNT_W  number of commits whose pattern differed from the previous committed pattern; wraps.

Behaviour:
- Digit table (active-low hex, digit:pattern):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - Blank is 7F. Any other pattern is invalid.
- Registers: last sample samp (7b), stability counter cnt (saturating, holds 0..STABLE_CYCLES), committed pattern comm (7b), state ∈ {LOCKED, SETTLE}.
- Every rising edge, HEX_in is compared with samp, then samp <= HEX_in.
- Mismatch on any edge:
  - cnt <= 1, state <= SETTLE, Valid <= 0.
  - Value, Invalid and Blank hold.
- Match in SETTLE:
  - cnt <= cnt+1.
  - Commit occurs on the edge where the new cnt equals STABLE_CYCLES.
  - With STABLE_CYCLES=1, the commit happens on the mismatch edge itself; that edge enters LOCKED directly.
- Commit edge actions:
  - comm <= HEX_in; state <= LOCKED; Update <= 1.
  - Decode HEX_in: digit → Value=digit, Valid=1, Invalid=0, Blank=0. Blank → Valid=0, Invalid=0, Blank=1, Value holds. Other → Valid=0, Invalid=1, Blank=0, Value holds.
  - ChangeCount += 1 (mod 2^COUNT_W) iff HEX_in != previous comm.
- Update is high for exactly one cycle after each commit; otherwise 0.
- Match in LOCKED: no change; cnt holds at STABLE_CYCLES.
- Latency: a new pattern applied before edge 1 and held gives Update/outputs visible after edge STABLE_CYCLES.
- Glitches shorter than STABLE_CYCLES never commit.
- A pattern that returns to the committed value after a glitch re-commits with an Update pulse, but ChangeCount does not increment.
- Reset (async, Resetn=0):
  - samp=7F, comm=7F, cnt=STABLE_CYCLES, state=LOCKED.
  - Value=0, Valid=0, Invalid=0, Blank=1, Update=0, ChangeCount=0.
  - Reset mid-SETTLE discards the pending pattern.
  - Release is synchronous to the next edge; if HEX_in=7F then, nothing happens.

Test Plan:
- Reset with HEX_in=7F, release, hold 10 cycles → Blank=1, Valid=0, Update never pulses, ChangeCount=0.
- STABLE_CYCLES=4; HEX_in=24 applied before edge 1 and held → Update high only after edge 4; Value=2, Valid=1, Blank=0, ChangeCount=1.
- Committed 2; drive 30 for 3 cycles, then back to 24 → Valid drops after the first 30 edge; 30 never commits; 24 re-commits 4 edges later with Value=2; ChangeCount stays 1.
- Drive 7F→79→40→00→0E, each held 6 cycles → Value sequence 1,0,8,F; four Update pulses; ChangeCount=4.
- HEX_in=55 held 4 cycles after Value=8 → Invalid=1, Valid=0, Value stays 8, ChangeCount increments.
- COUNT_W=2: five alternating commits of 40/79 → ChangeCount wraps 3→0→1. Separately, assert Resetn mid-SETTLE → all outputs return to reset values immediately.
